// File: rtl/gshare_btb_predictor.sv
// Fetch-stage branch predictor: gshare direction table, direct-mapped typed BTB,
// circular return address stack and speculative global history with repair.
module gshare_btb_predictor #(
   parameter int ADDR_W      = 32,
   parameter int PHT_ENTRIES = 256,
   parameter int BTB_ENTRIES = 64,
   parameter int RAS_DEPTH   = 4,
   parameter int GHR_BITS    = 8
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic [ADDR_W-1:0]   current_pc,
   input  logic                predict_valid,
   output logic                predict_taken,
   output logic [ADDR_W-1:0]   target_addr,
   output logic [GHR_BITS-1:0] predict_ghr,
   input  logic                update_valid,
   input  logic [ADDR_W-1:0]   update_pc,
   input  logic [ADDR_W-1:0]   update_target,
   input  logic                update_taken,
   input  logic [1:0]          update_type,
   input  logic                update_mispredict,
   input  logic [GHR_BITS-1:0] update_ghr
);

   localparam int BI = $clog2(BTB_ENTRIES);
   localparam int PI = $clog2(PHT_ENTRIES);
   localparam int RP = $clog2(RAS_DEPTH);
   localparam int TW = ADDR_W - BI - 2;

   localparam logic [1:0] T_BR   = 2'b00;
   localparam logic [1:0] T_JMP  = 2'b01;
   localparam logic [1:0] T_CALL = 2'b10;
   localparam logic [1:0] T_RET  = 2'b11;

   logic              btb_v_q   [BTB_ENTRIES];
   logic [TW-1:0]     btb_tag_q [BTB_ENTRIES];
   logic [ADDR_W-1:0] btb_tgt_q [BTB_ENTRIES];
   logic [1:0]        btb_type_q[BTB_ENTRIES];
   logic [1:0]        pht_q     [PHT_ENTRIES];
   logic [ADDR_W-1:0] ras_q     [RAS_DEPTH];
   logic [GHR_BITS-1:0] ghr_q;
   logic [RP-1:0]     ras_ptr_q;
   logic [RP:0]       ras_cnt_q;

   // Lookup side
   logic [BI-1:0]     l_idx;
   logic [TW-1:0]     l_tag;
   logic [PI-1:0]     l_pidx;
   logic              l_hit;
   logic [1:0]        l_type;
   logic [ADDR_W-1:0] l_btb_tgt;
   logic [ADDR_W-1:0] pc_plus4;
   logic [ADDR_W-1:0] ras_top;
   logic              ras_empty;
   logic              ras_full;

   assign l_idx     = current_pc[BI+1:2];
   assign l_tag     = current_pc[ADDR_W-1:BI+2];
   assign l_pidx    = current_pc[PI+1:2] ^ PI'(ghr_q);
   assign l_hit     = btb_v_q[l_idx] && (btb_tag_q[l_idx] == l_tag);
   assign l_type    = btb_type_q[l_idx];
   assign l_btb_tgt = btb_tgt_q[l_idx];
   assign pc_plus4  = current_pc + ADDR_W'(4);
   assign ras_top   = ras_q[ras_ptr_q - RP'(1)];
   assign ras_empty = (ras_cnt_q == '0);
   assign ras_full  = (ras_cnt_q == (RP+1)'(RAS_DEPTH));

   always_comb begin
      predict_taken = 1'b0;
      target_addr   = pc_plus4;
      if (l_hit) begin
         case (l_type)
            T_BR: begin
               if (pht_q[l_pidx][1]) begin
                  predict_taken = 1'b1;
                  target_addr   = l_btb_tgt;
               end
            end
            T_JMP, T_CALL: begin
               predict_taken = 1'b1;
               target_addr   = l_btb_tgt;
            end
            default: begin
               predict_taken = 1'b1;
               target_addr   = ras_empty ? l_btb_tgt : ras_top;
            end
         endcase
      end
   end

   assign predict_ghr = ghr_q;

   // Update side
   logic [BI-1:0]     u_idx;
   logic [PI-1:0]     u_pidx;
   logic [1:0]        u_ctr;
   logic [GHR_BITS:0] spec_shift;
   logic [GHR_BITS:0] repair_shift;
   logic              spec_br;
   logic              spec_call;
   logic              spec_ret;
   logic              unused_pc_bits;

   assign u_idx          = update_pc[BI+1:2];
   assign u_pidx         = update_pc[PI+1:2] ^ PI'(update_ghr);
   assign u_ctr          = pht_q[u_pidx];
   assign spec_shift     = {ghr_q, predict_taken};
   assign repair_shift   = {update_ghr, update_taken};
   assign spec_br        = predict_valid && l_hit && (l_type == T_BR);
   assign spec_call      = predict_valid && l_hit && (l_type == T_CALL);
   assign spec_ret       = predict_valid && l_hit && (l_type == T_RET);
   assign unused_pc_bits = ^update_pc[1:0];

   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int i = 0; i < BTB_ENTRIES; i++) btb_v_q[i] <= 1'b0;
         for (int i = 0; i < PHT_ENTRIES; i++) pht_q[i] <= 2'b01;
         ghr_q     <= '0;
         ras_ptr_q <= '0;
         ras_cnt_q <= '0;
      end else begin
         if (update_valid && update_type == T_BR) begin
            if (update_taken && u_ctr != 2'b11)
               pht_q[u_pidx] <= u_ctr + 2'b01;
            else if (!update_taken && u_ctr != 2'b00)
               pht_q[u_pidx] <= u_ctr - 2'b01;
         end
         // Not-taken branches never allocate, so cold branches cost no BTB space
         if (update_valid && (update_taken || update_type != T_BR)) begin
            btb_v_q[u_idx]    <= 1'b1;
            btb_tag_q[u_idx]  <= update_pc[ADDR_W-1:BI+2];
            btb_tgt_q[u_idx]  <= update_target;
            btb_type_q[u_idx] <= update_type;
         end
         if (update_valid && update_mispredict)
            ghr_q <= (update_type == T_BR) ? repair_shift[GHR_BITS-1:0] : update_ghr;
         else if (spec_br)
            ghr_q <= spec_shift[GHR_BITS-1:0];
         // Full stack overwrites the oldest entry; the pointer simply wraps
         if (spec_call) begin
            ras_q[ras_ptr_q] <= pc_plus4;
            ras_ptr_q        <= ras_ptr_q + RP'(1);
            if (!ras_full) ras_cnt_q <= ras_cnt_q + (RP+1)'(1);
         end else if (spec_ret && !ras_empty) begin
            ras_ptr_q <= ras_ptr_q - RP'(1);
            ras_cnt_q <= ras_cnt_q - (RP+1)'(1);
         end
      end
   end

endmodule

// File: tb/tb_gshare_btb_predictor.sv
// Bench for gshare_btb_predictor: directed vector table for the documented scenarios,
// then randomized traffic checked against an array/queue reference model.
module tb_gshare_btb_predictor;

   logic        CLK = 1'b0;
   logic        RST;
   logic [31:0] current_pc;
   logic        predict_valid;
   logic        predict_taken;
   logic [31:0] target_addr;
   logic [7:0]  predict_ghr;
   logic        update_valid;
   logic [31:0] update_pc;
   logic [31:0] update_target;
   logic        update_taken;
   logic [1:0]  update_type;
   logic        update_mispredict;
   logic [7:0]  update_ghr;

   gshare_btb_predictor dut (
      .CLK(CLK), .RST(RST),
      .current_pc(current_pc), .predict_valid(predict_valid),
      .predict_taken(predict_taken), .target_addr(target_addr), .predict_ghr(predict_ghr),
      .update_valid(update_valid), .update_pc(update_pc), .update_target(update_target),
      .update_taken(update_taken), .update_type(update_type),
      .update_mispredict(update_mispredict), .update_ghr(update_ghr)
   );

   // Clock / reset
   always #5 CLK = ~CLK;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      logic        rst;
      logic        pv;
      logic [31:0] pc;
      logic        uv;
      logic [31:0] upc;
      logic [31:0] utgt;
      logic        ut;
      logic [1:0]  uty;
      logic        um;
      logic [7:0]  ughr;
      logic        exp_t;
      logic [31:0] exp_tgt;
      logic [7:0]  exp_ghr;
   } vec_t;

   vec_t tbl[$];
   logic [40:0] exp_q[$];

   task automatic add(input logic rst, input logic pv, input logic [31:0] pc,
                      input logic uv, input logic [31:0] upc, input logic [31:0] utgt,
                      input logic ut, input logic [1:0] uty, input logic um, input logic [7:0] ughr,
                      input logic et, input logic [31:0] etgt, input logic [7:0] eghr);
      vec_t v;
      v.rst = rst; v.pv = pv; v.pc = pc; v.uv = uv; v.upc = upc; v.utgt = utgt;
      v.ut = ut; v.uty = uty; v.um = um; v.ughr = ughr;
      v.exp_t = et; v.exp_tgt = etgt; v.exp_ghr = eghr;
      tbl.push_back(v);
   endtask

   task automatic look(input logic pv, input logic [31:0] pc,
                       input logic et, input logic [31:0] etgt, input logic [7:0] eghr);
      add(1'b0, pv, pc, 1'b0, 32'h0, 32'h0, 1'b0, 2'b00, 1'b0, 8'h0, et, etgt, eghr);
   endtask

   // Driver
   task automatic drive(input vec_t v);
      RST = v.rst; predict_valid = v.pv; current_pc = v.pc;
      update_valid = v.uv; update_pc = v.upc; update_target = v.utgt;
      update_taken = v.ut; update_type = v.uty; update_mispredict = v.um; update_ghr = v.ughr;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference model
   bit          m_v  [64];
   int unsigned m_tag[64];
   logic [31:0] m_tgt[64];
   logic [1:0]  m_ty [64];
   int          m_pht[256];
   int          m_ghr;
   logic [31:0] m_ras[$];

   task automatic model_reset();
      for (int i = 0; i < 64; i++) m_v[i] = 1'b0;
      for (int i = 0; i < 256; i++) m_pht[i] = 1;
      m_ghr = 0;
      m_ras.delete();
   endtask

   function automatic bit m_hit(input logic [31:0] pc);
      int unsigned bi = (pc / 4) % 64;
      return m_v[bi] && (m_tag[bi] == pc / 256);
   endfunction

   task automatic model_predict(input logic [31:0] pc, output logic t, output logic [31:0] tgt);
      int unsigned bi = (pc / 4) % 64;
      t = 1'b0;
      tgt = pc + 4;
      if (m_hit(pc)) begin
         case (m_ty[bi])
            2'd0: if (m_pht[((pc / 4) % 256) ^ m_ghr] >= 2) begin t = 1'b1; tgt = m_tgt[bi]; end
            2'd1, 2'd2: begin t = 1'b1; tgt = m_tgt[bi]; end
            default: begin t = 1'b1; tgt = (m_ras.size() > 0) ? m_ras[$] : m_tgt[bi]; end
         endcase
      end
   endtask

   task automatic model_step(input vec_t v);
      logic        pt;
      logic [31:0] ptgt;
      int unsigned bi;
      int          pi;
      int          ghr_n;
      if (v.rst) begin
         model_reset();
         return;
      end
      model_predict(v.pc, pt, ptgt);
      bi = (v.pc / 4) % 64;
      ghr_n = m_ghr;
      if (v.pv && m_hit(v.pc)) begin
         if (m_ty[bi] == 2'd0) ghr_n = ((m_ghr * 2) + pt) % 256;
         else if (m_ty[bi] == 2'd2) begin
            m_ras.push_back(v.pc + 4);
            if (m_ras.size() > 4) void'(m_ras.pop_front());
         end else if (m_ty[bi] == 2'd3 && m_ras.size() > 0) void'(m_ras.pop_back());
      end
      if (v.uv) begin
         if (v.uty == 2'd0) begin
            pi = ((v.upc / 4) % 256) ^ v.ughr;
            if (v.ut && m_pht[pi] < 3) m_pht[pi]++;
            if (!v.ut && m_pht[pi] > 0) m_pht[pi]--;
         end
         if (v.ut || v.uty != 2'd0) begin
            bi = (v.upc / 4) % 64;
            m_v[bi] = 1'b1; m_tag[bi] = v.upc / 256; m_tgt[bi] = v.utgt; m_ty[bi] = v.uty;
         end
         if (v.um) ghr_n = (v.uty == 2'd0) ? ((v.ughr * 2) + v.ut) % 256 : v.ughr;
      end
      m_ghr = ghr_n;
   endtask

   initial begin
      vec_t v;
      logic        et;
      logic [31:0] etgt;
      logic [40:0] e;

      // Directed vectors; each row is one cycle, outputs sampled before its edge
      look(1'b1, 32'h100, 1'b0, 32'h104, 8'h0);
      add(0, 0, 32'h100, 1, 32'h200, 32'h180, 1, 2'b00, 0, 8'h0, 0, 32'h104, 8'h0);
      add(0, 0, 32'h200, 1, 32'h200, 32'h180, 1, 2'b00, 0, 8'h0, 1, 32'h180, 8'h0);
      look(1'b0, 32'h200, 1'b1, 32'h180, 8'h0);
      add(0, 0, 32'h200, 1, 32'h200, 32'h180, 0, 2'b00, 0, 8'h0, 1, 32'h180, 8'h0);
      add(0, 0, 32'h200, 1, 32'h200, 32'h180, 0, 2'b00, 0, 8'h0, 1, 32'h180, 8'h0);
      add(0, 0, 32'h200, 1, 32'h200, 32'h180, 0, 2'b00, 0, 8'h0, 0, 32'h204, 8'h0);
      look(1'b0, 32'h200, 1'b0, 32'h204, 8'h0);
      add(0, 0, 32'h100, 1, 32'h300, 32'h800, 1, 2'b10, 0, 8'h0, 0, 32'h104, 8'h0);
      for (int i = 0; i < 5; i++) look(1'b1, 32'h300, 1'b1, 32'h800, 8'h0);
      add(0, 0, 32'h100, 1, 32'h900, 32'hA00, 1, 2'b11, 0, 8'h0, 0, 32'h104, 8'h0);
      for (int i = 0; i < 4; i++) look(1'b1, 32'h900, 1'b1, 32'h304, 8'h0);
      look(1'b1, 32'h900, 1'b1, 32'hA00, 8'h0);
      look(1'b0, 32'h900, 1'b1, 32'hA00, 8'h0);
      add(0, 0, 32'h100, 1, 32'h208, 32'h280, 1, 2'b00, 0, 8'h0, 0, 32'h104, 8'h0);
      add(0, 0, 32'h100, 1, 32'h208, 32'h280, 1, 2'b00, 0, 8'h1, 0, 32'h104, 8'h0);
      add(0, 0, 32'h100, 1, 32'h208, 32'h280, 1, 2'b00, 0, 8'h3, 0, 32'h104, 8'h0);
      look(1'b1, 32'h208, 1'b1, 32'h280, 8'h0);
      look(1'b1, 32'h208, 1'b1, 32'h280, 8'h1);
      look(1'b1, 32'h208, 1'b1, 32'h280, 8'h3);
      add(0, 1, 32'h208, 1, 32'h208, 32'h280, 0, 2'b00, 1, 8'h1, 0, 32'h20C, 8'h7);
      look(1'b0, 32'h100, 1'b0, 32'h104, 8'h2);
      add(0, 0, 32'h100, 1, 32'h000, 32'h040, 1, 2'b01, 0, 8'h0, 0, 32'h104, 8'h2);
      add(0, 0, 32'h000, 1, 32'h100, 32'h080, 1, 2'b01, 0, 8'h0, 1, 32'h040, 8'h2);
      look(1'b0, 32'h000, 1'b0, 32'h004, 8'h2);
      look(1'b0, 32'h100, 1'b1, 32'h080, 8'h2);
      add(0, 0, 32'h400, 1, 32'h400, 32'h500, 1, 2'b01, 0, 8'h0, 0, 32'h404, 8'h2);
      look(1'b0, 32'h400, 1'b1, 32'h500, 8'h2);
      add(1, 1, 32'h400, 1, 32'h600, 32'h700, 1, 2'b01, 1, 8'h55, 1, 32'h500, 8'h2);
      look(1'b0, 32'h400, 1'b0, 32'h404, 8'h0);
      look(1'b0, 32'h600, 1'b0, 32'h604, 8'h0);

      v = '{rst: 1'b1, pv: 1'b0, pc: 32'h0, uv: 1'b0, upc: 32'h0, utgt: 32'h0, ut: 1'b0,
            uty: 2'b00, um: 1'b0, ughr: 8'h0, exp_t: 1'b0, exp_tgt: 32'h0, exp_ghr: 8'h0};
      @(negedge CLK); drive(v);
      @(negedge CLK); drive(v);
      @(posedge CLK);

      foreach (tbl[i]) begin
         @(negedge CLK);
         drive(tbl[i]);
         #1;
         check($sformatf("vec%0d.taken", i), {31'b0, predict_taken}, {31'b0, tbl[i].exp_t});
         check($sformatf("vec%0d.target", i), target_addr, tbl[i].exp_tgt);
         check($sformatf("vec%0d.ghr", i), {24'b0, predict_ghr}, {24'b0, tbl[i].exp_ghr});
      end

      // Randomized traffic against the reference model
      @(negedge CLK);
      v.rst = 1'b1; v.pv = 1'b0; v.uv = 1'b0;
      drive(v);
      @(posedge CLK);
      model_reset();
      for (int c = 0; c < 3000; c++) begin
         @(negedge CLK);
         v.rst  = ($urandom_range(0, 299) == 0);
         v.pv   = ($urandom_range(0, 3) != 0);
         v.pc   = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2);
         v.uv   = ($urandom_range(0, 1) == 0);
         v.upc  = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2);
         v.utgt = $urandom & 32'hFFFF_FFFC;
         v.ut   = $urandom_range(0, 1);
         v.uty  = $urandom_range(0, 3);
         v.um   = ($urandom_range(0, 7) == 0);
         v.ughr = ($urandom_range(0, 1) == 0) ? 8'(m_ghr) : 8'($urandom_range(0, 255));
         drive(v);
         model_predict(v.pc, et, etgt);
         exp_q.push_back({et, etgt, 8'(m_ghr)});
         #1;
         e = exp_q.pop_front();
         check($sformatf("rnd%0d.taken", c), {31'b0, predict_taken}, {31'b0, e[40]});
         check($sformatf("rnd%0d.target", c), target_addr, e[39:8]);
         check($sformatf("rnd%0d.ghr", c), {24'b0, predict_ghr}, {24'b0, e[7:0]});
         @(posedge CLK);
         model_step(v);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/gshare_btb_predictor.md
# gshare_btb_predictor

Parametrised next-generation branch predictor for the fetch stage: a gshare direction predictor, a direct-mapped BTB with per-entry control-flow type, a circular return address stack (RAS), and a speculative global history register (GHR) with misprediction repair. It supersedes the separate direction/BTB/RAS predictors with one block. Lookup is combinational from the fetch PC. All tables are updated from the execute-stage resolution port.

## Interface
- ADDR_W, 32, PC/target width.
- PHT_ENTRIES, 256, number of 2-bit counters; power of 2, ≥4.
- BTB_ENTRIES, 64, number of direct-mapped BTB entries; power of 2, ≥2.
- RAS_DEPTH, 4, RAS entries; power of 2, ≥2.
- GHR_BITS, 8, history length; 1 ≤ GHR_BITS ≤ log2(PHT_ENTRIES).

Ports:
- CLK  in  1  clock; all state changes on rising edge.
- RST  in  1  reset, synchronous, active-high.
- current_pc  in  ADDR_W  fetch PC.
- predict_valid  in  1  fetch advances this cycle; gates all speculative state changes.
- predict_taken  out  1  predicted redirect.
- target_addr  out  ADDR_W  predicted target; current_pc+4 when not taken.
- predict_ghr  out  GHR_BITS  GHR value used for this lookup; carried down the pipe.
- update_valid  in  1  resolved control-flow instruction.
- update_pc  in  ADDR_W  PC of resolved instruction.
- update_target  in  ADDR_W  resolved taken target.
- update_taken  in  1  resolved direction.
- update_type  in  2  00 branch, 01 jump, 10 call, 11 return.
- update_mispredict  in  1  direction or target mispredicted.
- update_ghr  in  GHR_BITS  predict_ghr captured at that instruction's lookup.

## Operation
- Indexing: BTB index = pc[log2(BTB_ENTRIES)+1:2], tag = pc[ADDR_W-1:log2(BTB_ENTRIES)+2]. PHT index = pc[log2(PHT_ENTRIES)+1:2] XOR zero-extended GHR.
- Lookup (combinational): hit = valid && tag match.
  - miss: not taken.
  - branch: taken = PHT counter MSB; target = BTB target.
  - jump or call: taken; target = BTB target.
  - return: if RAS non-empty, taken to RAS top; if empty, fall back to BTB target, taken.
- Speculative state (only when predict_valid):
  - hit on branch: GHR <= {GHR[GHR_BITS-2:0], predict_taken}.
  - hit on call: push current_pc+4. Full RAS: overwrite oldest (circular pointer wrap), count saturates at RAS_DEPTH.
  - hit on return with RAS non-empty: pop. Empty: no pop, count stays 0.
- Update (when update_valid):
  - branch: PHT entry indexed by update_pc XOR update_ghr: saturating increment if taken, decrement if not (saturate at 3 and 0).
  - BTB write when update_taken or type ≠ branch: set valid, tag, target, type. A not-taken branch never allocates. It does update the PHT.
  - update_mispredict && type==branch: GHR <= {update_ghr[GHR_BITS-2:0], update_taken}. Any other mispredict: GHR <= update_ghr. Repair overrides the same-cycle speculative shift.
  - RAS is not repaired on mispredict.
- Same-cycle lookup and update to the same entry: lookup sees the pre-update value.

## Timing
- Prediction latency 0 cycles (combinational from current_pc and state). Updates are visible to lookups starting the next cycle.
- Reset (RST high at edge): all BTB valid = 0; PHT counters = 2'b01; GHR = 0; RAS pointer = 0, count = 0.
- Reset outputs: predict_taken = 0, target_addr = current_pc+4, predict_ghr = 0.
- RST asserted mid-operation overrides every same-cycle update and push/pop.

## Test plan
- Reset, then lookup PC 0x100 -> predict_taken=0, target 0x104, predict_ghr=0.
- Update branch PC 0x200, taken, target 0x180, ghr 0 (twice). Then lookup 0x200 with ghr 0 -> taken, target 0x180. After 3 not-taken updates -> counter 0, not taken.
- Call at 0x300 (BTB type call, target 0x800), looked up 5 times with RAS_DEPTH=4. Then 5 return lookups at 0x900 -> targets 0x304 ×4. The fifth falls back to the BTB target with the RAS count at 0.
- Three predicted-taken branch lookups (GHR=0b111), then update_mispredict branch with update_ghr=0b00000001, not taken -> GHR=0b00000010 next cycle, ignoring the same-cycle speculative shift.
- BTB alias: PCs 0x0000 and 0x0100 (BTB_ENTRIES=64) -> second allocation evicts the first. Lookup of 0x0000 misses.
- Same-cycle update and lookup of 0x400 with a cold BTB -> lookup reports miss; next-cycle lookup hits.
